fpu_adder_arbiter: RTL

Shares one single-precision stb/ack floating-point adder among NUM_REQ independent requesters.
- Round-robin selects a requester and latches its operand pair.
- Drives the adder's three-phase handshake: operand a, then operand b, then result z.
- Returns the 32-bit result to the granted requester only.
- Sits between the adder and client datapaths (e.g. dot-product or accumulate engines); exactly one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_adder_arbiter_rr_pick.sv | 27 ++
 rtl/fpu_adder_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the arbiters that front the single-precision FP units.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RETURN = 3'd4
  } arb_state_e;

  localparam logic [FP_W-1:0] FP_ONE = 32'h3F800000;
  localparam logic [FP_W-1:0] FP_TWO = 32'h40000000;

endpackage

// File: rtl/fpu_adder_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after last_i, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic               any_valid_o,
  output logic [ID_W-1:0]    gnt_o
);

  always_comb begin
    int idx;
    any_valid_o = 1'b0;
    gnt_o       = '0;
    idx         = 0;
    // k = NUM_REQ revisits last_i itself, so it has the lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (!any_valid_o && req_i[idx]) begin
        any_valid_o = 1'b1;
        gnt_o       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_adder_arbiter.sv
// Shares one stb/ack FP adder among NUM_REQ requesters, one operation in flight at a time.
module fpu_adder_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_stb,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [FP_W-1:0]         res_z,
  output logic [NUM_REQ-1:0]      res_stb,
  input  logic [NUM_REQ-1:0]      res_ack,
  output logic [FP_W-1:0]         adder_a,
  output logic                    adder_a_stb,
  input  logic                    adder_a_ack,
  output logic [FP_W-1:0]         adder_b,
  output logic                    adder_b_stb,
  input  logic                    adder_b_ack,
  input  logic [FP_W-1:0]         adder_z,
  input  logic                    adder_z_stb,
  output logic                    adder_z_ack,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  arb_state_e           state_q;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      grant_id_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic [NUM_REQ-1:0]   res_stb_q;
  logic [FP_W-1:0]      res_z_q;
  logic [FP_W-1:0]      adder_a_q;
  logic [FP_W-1:0]      adder_b_q;
  logic                 adder_a_stb_q;
  logic                 adder_b_stb_q;
  logic                 adder_z_ack_q;
  logic                 busy_q;

  logic                 any_d;
  logic [ID_W-1:0]      gnt_d;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i       (req_stb),
    .last_i      (last_q),
    .any_valid_o (any_d),
    .gnt_o       (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      req_ack_q     <= '0;
      res_stb_q     <= '0;
      res_z_q       <= '0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      adder_a_stb_q <= 1'b0;
      adder_b_stb_q <= 1'b0;
      adder_z_ack_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            adder_a_q        <= req_a[int'(gnt_d)*FP_W +: FP_W];
            adder_b_q        <= req_b[int'(gnt_d)*FP_W +: FP_W];
            grant_id_q       <= gnt_d;
            req_ack_q[gnt_d] <= 1'b1;
            busy_q           <= 1'b1;
            adder_a_stb_q    <= 1'b1;
            state_q          <= SEND_A;
          end
        end
        SEND_A: begin
          if (adder_a_stb_q && adder_a_ack) begin
            adder_a_stb_q <= 1'b0;
            adder_b_stb_q <= 1'b1;
            state_q       <= SEND_B;
          end
        end
        SEND_B: begin
          if (adder_b_stb_q && adder_b_ack) begin
            adder_b_stb_q <= 1'b0;
            adder_z_ack_q <= 1'b1;
            state_q       <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (adder_z_ack_q && adder_z_stb) begin
            res_z_q               <= adder_z;
            adder_z_ack_q         <= 1'b0;
            res_stb_q[grant_id_q] <= 1'b1;
            state_q               <= RETURN;
          end
        end
        RETURN: begin
          // Only the granted requester's ack retires the result; the pointer moves here.
          if (res_stb_q[grant_id_q] && res_ack[grant_id_q]) begin
            res_stb_q <= '0;
            last_q    <= grant_id_q;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign res_stb     = res_stb_q;
  assign res_z       = res_z_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign adder_a_stb = adder_a_stb_q;
  assign adder_b_stb = adder_b_stb_q;
  assign adder_z_ack = adder_z_ack_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule
